// File: rtl/box_322_axil_cfg_master.sv
// AXI-Lite master for the 322 MHz box configuration slave: one command in flight,
// converted to AW/W/B or AR/R, with completion counters and a sticky timeout flag.
module box_322_axil_cfg_master #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic        axil_aclk,
  input  logic        axil_areset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_we,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        m_axil_awvalid,
  output logic [31:0] m_axil_awaddr,
  input  logic        m_axil_awready,
  output logic        m_axil_wvalid,
  output logic [31:0] m_axil_wdata,
  input  logic        m_axil_wready,
  input  logic        m_axil_bvalid,
  input  logic [1:0]  m_axil_bresp,
  output logic        m_axil_bready,
  output logic        m_axil_arvalid,
  output logic [31:0] m_axil_araddr,
  input  logic        m_axil_arready,
  input  logic        m_axil_rvalid,
  input  logic [31:0] m_axil_rdata,
  input  logic [1:0]  m_axil_rresp,
  output logic        m_axil_rready,
  output logic [15:0] wr_cnt,
  output logic [15:0] rd_cnt,
  output logic [15:0] err_cnt,
  output logic        timeout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_WR_B  = 3'd2,
    S_RD_AR = 3'd3,
    S_RD_R  = 3'd4,
    S_RSP   = 3'd5
  } state_t;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  state_t      state_r, state_s;
  logic        awvalid_r, wvalid_r, arvalid_r;
  logic [31:0] awaddr_r, wdata_r, araddr_r;
  logic        rsp_we_r;
  logic [31:0] rsp_rdata_r;
  logic [1:0]  rsp_resp_r;
  logic [15:0] wr_cnt_r, rd_cnt_r, err_cnt_r, tmo_cnt_r;
  logic        timeout_r;
  logic        accept_s, aw_done_s, w_done_s, b_done_s, r_done_s, in_flight_s;
  logic [1:0]  fin_resp_s;

  // Handshake and phase decodes shared by the sequential blocks.
  always_comb begin
    accept_s    = (state_r == S_IDLE) && cmd_valid;
    aw_done_s   = !awvalid_r || m_axil_awready;
    w_done_s    = !wvalid_r || m_axil_wready;
    b_done_s    = (state_r == S_WR_B) && m_axil_bvalid;
    r_done_s    = (state_r == S_RD_R) && m_axil_rvalid;
    in_flight_s = (state_r == S_WR) || (state_r == S_WR_B) ||
                  (state_r == S_RD_AR) || (state_r == S_RD_R);
    fin_resp_s  = b_done_s ? m_axil_bresp : m_axil_rresp;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (cmd_valid) begin
          state_s = cmd_we ? S_WR : S_RD_AR;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WR: begin
        if (aw_done_s && w_done_s) begin
          state_s = S_WR_B;
        end else begin
          state_s = S_WR;
        end
      end
      S_WR_B: begin
        if (m_axil_bvalid) begin
          state_s = S_RSP;
        end else begin
          state_s = S_WR_B;
        end
      end
      S_RD_AR: begin
        if (m_axil_arready) begin
          state_s = S_RD_R;
        end else begin
          state_s = S_RD_AR;
        end
      end
      S_RD_R: begin
        if (m_axil_rvalid) begin
          state_s = S_RSP;
        end else begin
          state_s = S_RD_R;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_RSP;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge axil_aclk or posedge axil_areset) begin
    if (axil_areset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request channels: each valid drops only after its own handshake.
  always_ff @(posedge axil_aclk or posedge axil_areset) begin
    if (axil_areset) begin
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      arvalid_r <= 1'b0;
      awaddr_r  <= 32'd0;
      wdata_r   <= 32'd0;
      araddr_r  <= 32'd0;
    end else begin
      if (accept_s && cmd_we) begin
        awaddr_r  <= cmd_addr;
        wdata_r   <= cmd_wdata;
        awvalid_r <= 1'b1;
        wvalid_r  <= 1'b1;
      end
      if (accept_s && !cmd_we) begin
        araddr_r  <= cmd_addr;
        arvalid_r <= 1'b1;
      end
      if ((state_r == S_WR) && awvalid_r && m_axil_awready) begin
        awvalid_r <= 1'b0;
      end
      if ((state_r == S_WR) && wvalid_r && m_axil_wready) begin
        wvalid_r <= 1'b0;
      end
      if ((state_r == S_RD_AR) && m_axil_arready) begin
        arvalid_r <= 1'b0;
      end
    end
  end

  // Response capture and completion counters, updated on the edge entering RSP.
  always_ff @(posedge axil_aclk or posedge axil_areset) begin
    if (axil_areset) begin
      rsp_we_r    <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_resp_r  <= 2'b00;
      wr_cnt_r    <= 16'd0;
      rd_cnt_r    <= 16'd0;
      err_cnt_r   <= 16'd0;
    end else begin
      if (b_done_s) begin
        rsp_we_r    <= 1'b1;
        rsp_rdata_r <= 32'd0;
        rsp_resp_r  <= m_axil_bresp;
        wr_cnt_r    <= wr_cnt_r + 16'd1;
      end
      if (r_done_s) begin
        rsp_we_r    <= 1'b0;
        rsp_rdata_r <= m_axil_rdata;
        rsp_resp_r  <= m_axil_rresp;
        rd_cnt_r    <= rd_cnt_r + 16'd1;
      end
      if ((b_done_s || r_done_s) && (fin_resp_s != 2'b00)) begin
        err_cnt_r <= sat_inc16(err_cnt_r);
      end
    end
  end

  // In-flight cycle counter; the flag is sticky and never aborts the transfer.
  always_ff @(posedge axil_aclk or posedge axil_areset) begin
    if (axil_areset) begin
      tmo_cnt_r <= 16'd0;
      timeout_r <= 1'b0;
    end else begin
      if (accept_s) begin
        tmo_cnt_r <= 16'd0;
      end else if (in_flight_s) begin
        tmo_cnt_r <= sat_inc16(tmo_cnt_r);
      end
      if (in_flight_s && ((tmo_cnt_r + 16'd1) == TIMEOUT_C)) begin
        timeout_r <= 1'b1;
      end
    end
  end

  assign cmd_ready      = (state_r == S_IDLE) && !axil_areset;
  assign rsp_valid      = (state_r == S_RSP);
  assign m_axil_bready  = (state_r == S_WR_B);
  assign m_axil_rready  = (state_r == S_RD_R);
  assign m_axil_awvalid = awvalid_r;
  assign m_axil_awaddr  = awaddr_r;
  assign m_axil_wvalid  = wvalid_r;
  assign m_axil_wdata   = wdata_r;
  assign m_axil_arvalid = arvalid_r;
  assign m_axil_araddr  = araddr_r;
  assign rsp_we         = rsp_we_r;
  assign rsp_rdata      = rsp_rdata_r;
  assign rsp_resp       = rsp_resp_r;
  assign wr_cnt         = wr_cnt_r;
  assign rd_cnt         = rd_cnt_r;
  assign err_cnt        = err_cnt_r;
  assign timeout        = timeout_r;

endmodule

// File: tb/tb_box_322_axil_cfg_master.sv
// Bench for box_322_axil_cfg_master: a delay-programmable AXI-Lite slave plus a
// transaction-level model of what every master output must be on each cycle.
module tb_box_322_axil_cfg_master;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_we;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [1:0]  bresp;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] araddr, rdata;
  logic [1:0]  rresp;
  logic [15:0] wr_cnt, rd_cnt, err_cnt;
  logic        timeout;

  box_322_axil_cfg_master #(.TIMEOUT(TMO)) dut (
    .axil_aclk(clk), .axil_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_awvalid(awvalid), .m_axil_awaddr(awaddr), .m_axil_awready(awready),
    .m_axil_wvalid(wvalid), .m_axil_wdata(wdata), .m_axil_wready(wready),
    .m_axil_bvalid(bvalid), .m_axil_bresp(bresp), .m_axil_bready(bready),
    .m_axil_arvalid(arvalid), .m_axil_araddr(araddr), .m_axil_arready(arready),
    .m_axil_rvalid(rvalid), .m_axil_rdata(rdata), .m_axil_rresp(rresp),
    .m_axil_rready(rready),
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .err_cnt(err_cnt), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // slave knobs
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit rand_dly = 1'b0;
  int rr_mode = 0;

  // model state
  bit          outst, done, aw_got, w_got, ar_got;
  bit          m_we;
  logic [31:0] m_addr, m_wdata;
  bit          e_we;
  logic [31:0] e_rdata;
  logic [1:0]  e_resp;
  logic [15:0] m_wr, m_rd, m_err;
  bit          m_tmo;
  int          flight;
  int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
  logic [31:0] smem [16];
  logic [31:0] mmem [16];
  logic [31:0] s_awaddr, s_wdata, s_araddr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [1:0] resp_for(input logic [31:0] a);
    if (a[9]) return 2'b10;
    else if (a[10]) return 2'b11;
    else return 2'b00;
  endfunction

  task automatic model_reset();
    outst = 0; done = 0; aw_got = 0; w_got = 0; ar_got = 0; m_we = 0;
    m_wr = 16'd0; m_rd = 16'd0; m_err = 16'd0; m_tmo = 0; flight = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
  endtask

  // slave + reference model + per-cycle compare
  initial begin : slave_model
    bit h_cmd, h_aw, h_w, h_b, h_ar, h_r, h_rsp, c_we;
    logic [31:0] c_addr, c_wdata;
    for (int i = 0; i < 16; i++) begin smem[i] = 32'd0; mmem[i] = 32'd0; end
    model_reset();
    forever begin
      @(negedge clk);
      {h_cmd, h_aw, h_w, h_b, h_ar, h_r, h_rsp} = 7'd0;
      if (!rst) begin
        chk("cmd_ready", cmd_ready, !outst);
        chk("awvalid", awvalid, outst && m_we && !aw_got);
        chk("wvalid", wvalid, outst && m_we && !w_got);
        chk("arvalid", arvalid, outst && !m_we && !ar_got);
        chk("bready", bready, outst && m_we && aw_got && w_got && !done);
        chk("rready", rready, outst && !m_we && ar_got && !done);
        chk("rsp_valid", rsp_valid, done);
        if (awvalid) chk("awaddr", awaddr, m_addr);
        if (wvalid) chk("wdata", wdata, m_wdata);
        if (arvalid) chk("araddr", araddr, m_addr);
        if (done) begin
          chk("rsp_we", rsp_we, e_we);
          chk("rsp_rdata", rsp_rdata, e_rdata);
          chk("rsp_resp", rsp_resp, e_resp);
        end
        chk("wr_cnt", wr_cnt, m_wr);
        chk("rd_cnt", rd_cnt, m_rd);
        chk("err_cnt", err_cnt, m_err);
        chk("timeout", timeout, m_tmo);
        h_cmd = cmd_valid && cmd_ready;
        c_we = cmd_we; c_addr = cmd_addr; c_wdata = cmd_wdata;
        h_aw = awvalid && awready;
        h_w = wvalid && wready;
        h_b = bvalid && bready;
        h_ar = arvalid && arready;
        h_r = rvalid && rready;
        h_rsp = rsp_valid && rsp_ready;
        if (h_aw) s_awaddr = awaddr;
        if (h_w) s_wdata = wdata;
        if (h_ar) s_araddr = araddr;
        if (outst && !done) begin
          flight++;
          if (flight >= TMO) m_tmo = 1;
        end
      end
      @(posedge clk);
      #1;
      if (rst) begin
        model_reset();
        continue;
      end
      if (h_rsp) begin outst = 0; done = 0; end
      if (h_aw) begin aw_got = 1; aw_wait = 0; end
      if (h_w) begin w_got = 1; w_wait = 0; end
      if (h_ar) begin ar_got = 1; ar_wait = 0; end
      if (h_b) begin
        done = 1; m_wr = m_wr + 16'd1;
        smem[s_awaddr[5:2]] = s_wdata;
      end
      if (h_r) begin done = 1; m_rd = m_rd + 16'd1; end
      if ((h_b || h_r) && e_resp != 2'b00 && m_err != 16'hFFFF) m_err = m_err + 16'd1;
      if (h_cmd) begin
        outst = 1; done = 0; aw_got = 0; w_got = 0; ar_got = 0; flight = 0;
        m_we = c_we; m_addr = c_addr; m_wdata = c_wdata;
        e_we = c_we; e_resp = resp_for(c_addr);
        e_rdata = c_we ? 32'd0 : mmem[c_addr[5:2]];
        if (c_we) mmem[c_addr[5:2]] = c_wdata;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        if (rand_dly) begin
          aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
          b_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
          r_dly = $urandom_range(0, 3);
        end
      end
      if (awvalid && aw_wait >= aw_dly) awready = 1'b1;
      else begin awready = 1'b0; if (awvalid) aw_wait++; end
      if (wvalid && w_wait >= w_dly) wready = 1'b1;
      else begin wready = 1'b0; if (wvalid) w_wait++; end
      if (arvalid && ar_wait >= ar_dly) arready = 1'b1;
      else begin arready = 1'b0; if (arvalid) ar_wait++; end
      if (outst && m_we && aw_got && w_got && !done && b_wait >= b_dly) begin
        bvalid = 1'b1; bresp = resp_for(s_awaddr);
      end else begin
        bvalid = 1'b0; bresp = 2'b00;
        if (outst && m_we && aw_got && w_got && !done) b_wait++;
      end
      if (outst && !m_we && ar_got && !done && r_wait >= r_dly) begin
        rvalid = 1'b1; rdata = smem[s_araddr[5:2]]; rresp = resp_for(s_araddr);
      end else begin
        rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
        if (outst && !m_we && ar_got && !done) r_wait++;
      end
    end
  end

  // response-ready driver
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rr_mode == 0) rsp_ready = 1'b1;
      else if (rr_mode == 1) rsp_ready = 1'($urandom_range(0, 1));
      else rsp_ready = 1'b0;
    end
  end

  task automatic send_cmd(input bit we, input logic [31:0] a, input logic [31:0] d, output int acc);
    acc = -1;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin acc = cyc; break; end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("cmd_accepted_in_time", acc >= 0, 1);
  endtask

  task automatic finish_rsp(input int acc, output int lat, output logic [31:0] rd, output logic [1:0] rs);
    lat = -1; rd = 32'd0; rs = 2'b00;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rsp_valid && lat < 0) begin lat = cyc - acc; rd = rsp_rdata; rs = rsp_resp; end
      if (rsp_valid && rsp_ready) break;
    end
    @(posedge clk);
    #1;
    chk("rsp_in_time", lat >= 0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, lat;
    logic [31:0] rd;
    logic [1:0] rs;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'd0; cmd_wdata = 32'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("cmd_ready_in_reset", cmd_ready, 0);
    chk("awvalid_in_reset", awvalid, 0);
    #2 rst = 1'b0;
    @(negedge clk);
    #1;
    chk("cmd_ready_after_reset", cmd_ready, 1);
    chk("wr_cnt_after_reset", wr_cnt, 0);
    @(posedge clk);
    #1;

    // write then read, zero-wait slave
    send_cmd(1'b1, 32'h0000_0000, 32'h0A00_0001, acc);
    finish_rsp(acc, lat, rd, rs);
    chk("wr_latency", lat, 3);
    chk("wr_resp", rs, 2'b00);
    send_cmd(1'b0, 32'h0000_0000, 32'd0, acc);
    finish_rsp(acc, lat, rd, rs);
    chk("rd_latency", lat, 3);
    chk("rd_data", rd, 32'h0A00_0001);
    chk("wr_cnt_1", wr_cnt, 1);
    chk("rd_cnt_1", rd_cnt, 1);

    // back-to-back spacing
    send_cmd(1'b1, 32'h0000_0010, 32'h1111_2222, acc);
    finish_rsp(acc, lat, rd, rs);
    send_cmd(1'b1, 32'h0000_0014, 32'h3333_4444, acc2);
    finish_rsp(acc2, lat, rd, rs);
    chk("b2b_spacing", acc2 - acc, 4);

    // skewed write handshakes, both orders
    aw_dly = 0; w_dly = 5;
    send_cmd(1'b1, 32'h0000_0020, 32'hC0A8_0101, acc);
    finish_rsp(acc, lat, rd, rs);
    aw_dly = 5; w_dly = 0;
    send_cmd(1'b1, 32'h0000_0024, 32'h0011_2233, acc);
    finish_rsp(acc, lat, rd, rs);
    aw_dly = 0; w_dly = 0;
    chk("wr_cnt_5", wr_cnt, 5);

    // error responses
    for (int i = 0; i < 3; i++) begin
      send_cmd(1'b0, 32'h0000_0200 + 32'(i * 4), 32'd0, acc);
      finish_rsp(acc, lat, rd, rs);
      chk("err_rresp", rs, 2'b10);
    end
    chk("err_cnt_3", err_cnt, 3);
    chk("rd_cnt_4", rd_cnt, 4);

    // response backpressure
    rr_mode = 2;
    send_cmd(1'b0, 32'h0000_0000, 32'd0, acc);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h0A00_0001);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    rr_mode = 0;
    finish_rsp(acc, lat, rd, rs);

    // timeout: arready held off for 40 cycles
    chk("timeout_clear", timeout, 0);
    ar_dly = 40;
    send_cmd(1'b0, 32'h0000_0004, 32'd0, acc);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cyc == acc + 10) chk("timeout_early", timeout, 0);
      if (cyc == acc + 20) chk("timeout_set", timeout, 1);
      if (cyc == acc + 30) begin chk("arvalid_held", arvalid, 1); break; end
    end
    finish_rsp(acc, lat, rd, rs);
    ar_dly = 0;
    chk("timeout_rd_cnt", rd_cnt, 6);
    chk("timeout_sticky", timeout, 1);

    // randomized traffic
    rand_dly = 1'b1;
    rr_mode = 1;
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 3) == 0) a = a | 32'h0000_0200;
      if ($urandom_range(0, 7) == 0) a = a | 32'h0000_0400;
      send_cmd(1'($urandom_range(0, 1)), a, $urandom, acc);
      finish_rsp(acc, lat, rd, rs);
    end
    rand_dly = 1'b0;
    rr_mode = 0;
    aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0;

    // reset while waiting in the write-response phase
    b_dly = 20;
    send_cmd(1'b1, 32'h0000_0030, 32'hDEAD_BEEF, acc);
    acc2 = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bready) begin acc2 = 1; break; end
    end
    chk("reached_wr_b", acc2, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rready", rready, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_we", rsp_we, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    chk("rst_rd_cnt", rd_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_timeout", timeout, 0);
    b_dly = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_wr_cnt", wr_cnt, 0);
    chk("post_rst_timeout", timeout, 0);
    @(posedge clk);
    #1;
    send_cmd(1'b0, 32'h0000_0004, 32'd0, acc);
    finish_rsp(acc, lat, rd, rs);
    chk("post_rst_rd_cnt", rd_cnt, 1);
    chk("post_rst_latency", lat, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
